// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: state encoding, field widths,
// ROM word layout and the song ROM contents.
package song_pkg;

    localparam int DEF_NOTE_W       = 6;
    localparam int DEF_IDX_W        = 5;
    localparam int DEF_SONG_W       = 2;
    localparam int DEF_GUARD_CYCLES = 2;

    localparam int ROM_AW   = DEF_SONG_W + DEF_IDX_W;
    localparam int WORD_W   = 2 * DEF_NOTE_W;
    localparam int NOTE_MSB = 11;
    localparam int NOTE_LSB = 6;
    localparam int DUR_MSB  = 5;
    localparam int DUR_LSB  = 0;

    localparam int END_DURATION = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Song table, addressed {song, idx}; a zero duration ends a song.
    function automatic logic [WORD_W-1:0] song_rom_word(input logic [ROM_AW-1:0] addr);
        logic [DEF_SONG_W-1:0] s;
        logic [DEF_IDX_W-1:0]  i;
        logic [DEF_NOTE_W-1:0] n;
        logic [DEF_NOTE_W-1:0] d;
        s = addr[ROM_AW-1:DEF_IDX_W];
        i = addr[DEF_IDX_W-1:0];
        n = '0;
        d = '0;
        case (s)
            2'd0: begin
                if (i < 5'd10) begin
                    n = 6'd20 + {1'b0, i};
                    d = 6'd12 + {1'b0, i};
                end
            end
            2'd1: begin
                if (i < 5'd3) begin
                    n = 6'd30 + {1'b0, i};
                    d = 6'd4 + {1'b0, i};
                end else if (i == 5'd3) begin
                    n = 6'd5;
                end
            end
            2'd2: begin
                if (i < 5'd6) begin
                    n = 6'd40 + {1'b0, i};
                    d = 6'd2 + {1'b0, i};
                end
            end
            default: begin
                n = {i, 1'b0} + {1'b0, i};
                d = {1'b0, i} + 6'd1;
            end
        endcase
        return {n, d};
    endfunction

endpackage

// File: rtl/song_rom.sv
// 128 x 12 song ROM with a registered read (one cycle of latency).
module song_rom
    import song_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [WORD_W-1:0] dout
);

    always_ff @(posedge clk) begin
        dout <= song_rom_word(addr);
    end

endmodule

// File: rtl/song_reader.sv
// Walks the selected song in ROM and hands each note to the note player with a
// load strobe, then waits for the player's done before fetching the next note.
//   state | meaning
//   IDLE  | after reset, waiting for play or new_song
//   FETCH | ROM address presented
//   LATCH | ROM data valid, captured on exit
//   ISSUE | load_new_note high
//   GUARD | stale note_done ignored while the player reloads
//   WAIT  | waiting for note_done
//   DONE  | song finished, waits for new_song
module song_reader
    import song_pkg::*;
#(
    parameter int NOTE_W       = DEF_NOTE_W,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int SONG_W       = DEF_SONG_W,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              new_song,
    input  logic              note_done,
    output logic [NOTE_W-1:0] note_to_load,
    output logic [NOTE_W-1:0] duration_to_load,
    output logic              load_new_note,
    output logic              song_done,
    output logic [IDX_W-1:0]  note_index
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0]     GUARD_INIT = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]  IDX_LAST   = '1;
    localparam logic [NOTE_W-1:0] END_DUR    = NOTE_W'(END_DURATION);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [NOTE_W-1:0]   dur_q, dur_d;
    logic [GW-1:0]       guard_q, guard_d;

    logic [WORD_W-1:0]   rom_dout;
    logic [NOTE_W-1:0]   rom_note;
    logic [NOTE_W-1:0]   rom_dur;
    logic                last_note;
    state_e              adv_state;
    logic [IDX_W-1:0]    adv_idx;

    song_rom u_rom (
        .clk  (clk),
        .addr ({song_q, idx_q}),
        .dout (rom_dout)
    );

    assign rom_note = rom_dout[NOTE_MSB:NOTE_LSB];
    assign rom_dur  = rom_dout[DUR_MSB:DUR_LSB];

    // The last index ends the song instead of rolling over to note 0.
    assign last_note = (idx_q == IDX_LAST);
    assign adv_state = last_note ? ST_DONE : ST_FETCH;
    assign adv_idx   = last_note ? idx_q : idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        song_d  = song_q;
        note_d  = note_q;
        dur_d   = dur_q;
        guard_d = guard_q;
        if (new_song) begin
            song_d  = song;
            idx_d   = '0;
            state_d = ST_FETCH;
        end else if (play) begin
            case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FETCH: state_d = ST_LATCH;
                ST_LATCH: begin
                    note_d  = rom_note;
                    dur_d   = rom_dur;
                    state_d = (rom_dur == END_DUR) ? ST_DONE : ST_ISSUE;
                end
                ST_ISSUE: begin
                    guard_d = GUARD_INIT;
                    state_d = (GUARD_CYCLES == 0) ? ST_WAIT : ST_GUARD;
                end
                ST_GUARD: begin
                    if (guard_q != '0) begin
                        guard_d = guard_q - GW'(1);
                    end else if (note_done) begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (note_done) begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            song_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            song_q  <= song_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            guard_q <= guard_d;
        end
    end

    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign load_new_note    = (state_q == ST_ISSUE);
    assign song_done        = (state_q == ST_DONE);
    assign note_index       = idx_q;

endmodule

// File: tb/tb_song_reader.sv
// Scoreboarded bench for song_reader: a song-level model predicts every load and
// end-of-song event, a negedge monitor compares them, directed checks cover timing.
module tb_song_reader;

    localparam int G = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b0;
    logic [1:0] song = 2'd0;
    logic       new_song = 1'b0;
    logic       note_done = 1'b0;
    logic [5:0] note_to_load;
    logic [5:0] duration_to_load;
    logic       load_new_note;
    logic       song_done;
    logic [4:0] note_index;

    song_reader #(
        .NOTE_W(6), .IDX_W(5), .SONG_W(2), .GUARD_CYCLES(G)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .new_song         (new_song),
        .note_done        (note_done),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .song_done        (song_done),
        .note_index       (note_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int idx;
        int note;
        int dur;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ref_note[4][32];
    int   ref_dur[4][32];
    int   m_song;
    int   m_idx;
    bit   prev_load = 0;
    bit   prev_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic build_ref();
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 32; i++) begin
                ref_note[s][i] = 0;
                ref_dur[s][i]  = 0;
            end
        for (int i = 0; i < 10; i++) begin
            ref_note[0][i] = 20 + i;
            ref_dur[0][i]  = 12 + i;
        end
        for (int i = 0; i < 3; i++) begin
            ref_note[1][i] = 30 + i;
            ref_dur[1][i]  = 4 + i;
        end
        ref_note[1][3] = 5;
        for (int i = 0; i < 6; i++) begin
            ref_note[2][i] = 40 + i;
            ref_dur[2][i]  = 2 + i;
        end
        for (int i = 0; i < 32; i++) begin
            ref_note[3][i] = (3 * i) % 64;
            ref_dur[3][i]  = i + 1;
        end
    endtask

    task automatic model_push(input int s, input int i, input bit done);
        exp_t x;
        x.is_done = done;
        x.idx     = i;
        x.note    = ref_note[s][i];
        x.dur     = ref_dur[s][i];
        sb.push_back(x);
    endtask

    task automatic model_start(input int s);
        m_song = s;
        m_idx  = 0;
        model_push(s, 0, ref_dur[s][0] == 0);
    endtask

    task automatic model_advance();
        if (m_idx == 31) begin
            model_push(m_song, 31, 1);
        end else begin
            m_idx++;
            model_push(m_song, m_idx, ref_dur[m_song][m_idx] == 0);
        end
    endtask

    // Monitor: every new load strobe or end-of-song pops one prediction.
    always @(negedge clk) begin
        if (reset) begin
            prev_load = 0;
            prev_done = 0;
        end else begin
            if ((load_new_note && !prev_load) || (song_done && !prev_done)) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected_event: got load=%0d done=%0d idx=%0d, required no event",
                             load_new_note, song_done, note_index);
                end else begin
                    n_pass++;
                    e = sb.pop_front();
                    chk("sb_event_kind", int'(song_done), int'(e.is_done));
                    chk("sb_note", int'(note_to_load), e.note);
                    chk("sb_duration", int'(duration_to_load), e.dur);
                    chk("sb_index", int'(note_index), e.idx);
                end
            end
            prev_load = load_new_note;
            prev_done = song_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(output int n, output bit done);
        n = 0;
        done = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            n++;
            if (load_new_note) return;
            if (song_done) begin
                done = 1;
                return;
            end
        end
        chk("wait_load_timeout", int'(load_new_note), 1);
        done = 1;
    endtask

    task automatic pulse_done();
        note_done = 1'b1;
        model_advance();
        tick();
        note_done = 1'b0;
    endtask

    task automatic serve_from_load();
        repeat (1 + G + $urandom_range(0, 3)) tick();
        pulse_done();
    endtask

    task automatic do_new_song(input int s);
        song = 2'(s);
        new_song = 1'b1;
        model_start(s);
        tick();
        new_song = 1'b0;
    endtask

    task automatic play_out(output int loads, output int last_gap);
        int n;
        bit d;
        loads = 0;
        last_gap = 0;
        for (int k = 0; k < 40; k++) begin
            wait_load(n, d);
            last_gap = n;
            if (d) return;
            loads++;
            serve_from_load();
        end
        chk("play_out_bounded", int'(song_done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, cnt, loads, gap, bad;
        bit  d;
        build_ref();

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_load", int'(load_new_note), 0);
        chk("rst_done", int'(song_done), 0);
        chk("rst_note", int'(note_to_load), 0);
        chk("rst_dur", int'(duration_to_load), 0);
        chk("rst_idx", int'(note_index), 0);

        // Start latency and first note from IDLE.
        play = 1'b1;
        model_start(0);
        tick();
        chk("start_e0_load", int'(load_new_note), 0);
        tick();
        chk("start_e1_load", int'(load_new_note), 0);
        tick();
        chk("start_e2_load", int'(load_new_note), 1);
        chk("start_note", int'(note_to_load), 20);
        chk("start_dur", int'(duration_to_load), 12);
        chk("start_idx", int'(note_index), 0);

        // note_done held from the load: only the guard delays the advance.
        note_done = 1'b1;
        model_advance();
        tick();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            cnt++;
            if (note_index != 5'd0) break;
        end
        note_done = 1'b0;
        chk("guard_cycles", cnt, G);
        chk("guard_idx", int'(note_index), 1);
        wait_load(n, d);
        chk("gap_to_next_load", n, 2);

        // Play song 0 up to note 7, then switch to song 2 while waiting.
        for (int k = 1; k < 7; k++) begin
            serve_from_load();
            wait_load(n, d);
        end
        chk("note7_idx", int'(note_index), 7);
        repeat (1 + G) tick();
        do_new_song(2);
        chk("newsong_idx", int'(note_index), 0);
        chk("newsong_load", int'(load_new_note), 0);
        chk("newsong_done", int'(song_done), 0);
        wait_load(n, d);
        chk("newsong_latency", n, 2);

        // Pause for 5 edges while the load strobe is up.
        cnt = 1;
        play = 1'b0;
        repeat (5) begin
            tick();
            if (load_new_note) cnt++;
        end
        play = 1'b1;
        tick();
        chk("pause_load_cycles", cnt, 6);
        chk("pause_load_cleared", int'(load_new_note), 0);
        repeat (G + $urandom_range(0, 2)) tick();
        pulse_done();
        play_out(loads, gap);
        chk("song2_loads_after_first", loads, 5);

        // Song 1 ends at word 3 via the end marker.
        do_new_song(1);
        play_out(loads, gap);
        chk("song1_loads", loads, 3);
        chk("song1_done_latency", gap, 2);
        chk("song1_idx", int'(note_index), 3);
        cnt = 0;
        bad = 0;
        repeat (100) begin
            tick();
            if (load_new_note) cnt++;
            if (!song_done) bad++;
        end
        chk("done_extra_loads", cnt, 0);
        chk("done_dropped_cycles", bad, 0);

        // Asynchronous reset while in the guard window.
        do_new_song(0);
        wait_load(n, d);
        serve_from_load();
        wait_load(n, d);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("areset_load", int'(load_new_note), 0);
        chk("areset_done", int'(song_done), 0);
        chk("areset_note", int'(note_to_load), 0);
        chk("areset_dur", int'(duration_to_load), 0);
        chk("areset_idx", int'(note_index), 0);
        sb.delete();
        tick();
        reset = 1'b0;
        model_start(0);
        wait_load(n, d);
        chk("replay_latency", n, 3);

        // Song 3 uses every index and ends on the last one.
        do_new_song(3);
        play_out(loads, gap);
        chk("song3_loads", loads, 32);
        chk("song3_done_latency", gap, 1);
        chk("song3_idx", int'(note_index), 31);
        cnt = 0;
        repeat (20) begin
            tick();
            if (load_new_note) cnt++;
        end
        chk("song3_extra_loads", cnt, 0);

        // Random song switches at random points.
        for (int r = 0; r < 8; r++) begin
            do_new_song($urandom_range(0, 3));
            n = $urandom_range(1, 12);
            d = 0;
            for (int k = 0; k < n; k++) begin
                wait_load(gap, d);
                if (d) break;
                serve_from_load();
            end
            if (!d) wait_load(gap, d);
        end

        repeat (5) tick();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
